// File: rtl/qam_demap_sequencer_if.sv
// rtl/qam_demap_sequencer_if.sv - byte output stream between the demap sequencer and the output stage
interface qam_demap_sequencer_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output byte_data,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_data,
        input  byte_valid,
        output byte_ready
    );
endinterface

// File: rtl/qam_demap_sequencer.sv
// rtl/qam_demap_sequencer.sv - 16QAM demapper controller: DC-offset calibration and symbol-to-byte packing
module qam_demap_sequencer #(
    parameter int CAL_LOG2 = 4
) (
    input  logic                  symbol_clock,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  cal,
    input  logic signed [7:0]     I_in,
    input  logic signed [7:0]     Q_in,
    input  logic [3:0]            sym_in,
    output logic signed [7:0]     offset_i,
    output logic signed [7:0]     offset_q,
    output logic                  latch_offset,
    output logic                  overflow,
    output logic [1:0]            state,
    qam_demap_sequencer_if.master byte_if
);
    localparam int AW = 8 + CAL_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAL  = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic signed [AW-1:0]  acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic [CAL_LOG2-1:0]   cnt_q, cnt_d;
    logic signed [7:0]     offset_i_q, offset_i_d, offset_q_q, offset_q_d;
    logic                  latch_q, latch_d;
    logic                  phase_q, phase_d;
    logic [3:0]            hi_q, hi_d;
    logic [7:0]            head_q, head_d, tail_q, tail_d;
    logic [1:0]            fill_q, fill_d;
    logic                  overflow_q, overflow_d;

    logic                  cal_entry, capture, push, pop;
    logic signed [AW-1:0]  ext_i, ext_q, sum_i, sum_q, shr_i, shr_q;
    logic [7:0]            new_byte;

    always_comb begin
        state_d   = state_q;
        cal_entry = 1'b0;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cal) begin
                    state_d   = CAL;
                    cal_entry = 1'b1;
                end else if (en) begin
                    state_d = RUN;
                end
            end
            CAL: begin
                if (&cnt_q) state_d = IDLE;
            end
            RUN: begin
                if (cal) begin
                    state_d   = CAL;
                    cal_entry = 1'b1;
                end else if (!en) begin
                    state_d = IDLE;
                end else begin
                    capture = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Accumulators are AW bits wide, so 2^CAL_LOG2 signed 8-bit samples cannot overflow.
    always_comb begin
        ext_i      = {{CAL_LOG2{I_in[7]}}, I_in};
        ext_q      = {{CAL_LOG2{Q_in[7]}}, Q_in};
        sum_i      = acc_i_q + ext_i;
        sum_q      = acc_q_q + ext_q;
        shr_i      = sum_i >>> CAL_LOG2;
        shr_q      = sum_q >>> CAL_LOG2;
        acc_i_d    = acc_i_q;
        acc_q_d    = acc_q_q;
        cnt_d      = cnt_q;
        offset_i_d = offset_i_q;
        offset_q_d = offset_q_q;
        latch_d    = 1'b0;
        if (cal_entry) begin
            acc_i_d = '0;
            acc_q_d = '0;
            cnt_d   = '0;
        end else if (state_q == CAL) begin
            acc_i_d = sum_i;
            acc_q_d = sum_q;
            cnt_d   = cnt_q + {{(CAL_LOG2-1){1'b0}}, 1'b1};
            if (&cnt_q) begin
                offset_i_d = shr_i[7:0];
                offset_q_d = shr_q[7:0];
                latch_d    = 1'b1;
            end
        end
    end

    // Capture only on edges that keep us in RUN, so an exit never completes a byte.
    always_comb begin
        phase_d    = capture ? ~phase_q : 1'b0;
        hi_d       = (capture && !phase_q) ? sym_in : hi_q;
        new_byte   = {hi_q, sym_in};
        push       = capture && phase_q;
        pop        = (fill_q != 2'd0) && byte_if.byte_ready;
        head_d     = head_q;
        tail_d     = tail_q;
        fill_d     = fill_q;
        overflow_d = overflow_q;
        if (push && pop) begin
            if (fill_q == 2'd2) begin
                head_d = tail_q;
                tail_d = new_byte;
            end else begin
                head_d = new_byte;
            end
        end else if (pop) begin
            head_d = tail_q;
            fill_d = fill_q - 2'd1;
        end else if (push) begin
            case (fill_q)
                2'd0: begin
                    head_d = new_byte;
                    fill_d = 2'd1;
                end
                2'd1: begin
                    tail_d = new_byte;
                    fill_d = 2'd2;
                end
                default: overflow_d = 1'b1;
            endcase
        end
        if (cal_entry) overflow_d = 1'b0;
    end

    always_ff @(posedge symbol_clock) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_i_q    <= '0;
            acc_q_q    <= '0;
            cnt_q      <= '0;
            offset_i_q <= '0;
            offset_q_q <= '0;
            latch_q    <= 1'b0;
            phase_q    <= 1'b0;
            hi_q       <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_i_q    <= acc_i_d;
            acc_q_q    <= acc_q_d;
            cnt_q      <= cnt_d;
            offset_i_q <= offset_i_d;
            offset_q_q <= offset_q_d;
            latch_q    <= latch_d;
            phase_q    <= phase_d;
            hi_q       <= hi_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            fill_q     <= fill_d;
            overflow_q <= overflow_d;
        end
    end

    assign offset_i           = offset_i_q;
    assign offset_q           = offset_q_q;
    assign latch_offset       = latch_q;
    assign overflow           = overflow_q;
    assign state              = state_q;
    assign byte_if.byte_data  = head_q;
    assign byte_if.byte_valid = (fill_q != 2'd0);
endmodule
